// File: rtl/pcie_axil_regs.sv
// pcie_axil_regs
// AXI4-Lite slave register file terminating BAR0 accesses from the PCIe
// AXI-MM bridge. Register map (decoded on addr[11:2]):
//   0x000 ID      RO  ID_VALUE
//   0x004 SCRATCH RW  32 bits
//   0x008 CTRL    RW  bits [3:0] stored, upper bits read 0
//   0x00C CYCLES  RO  free-running cycle counter
//   0x010 WRCNT   RO  count of completed write responses (any address)
// Unmapped offsets: writes ignored with SLVERR, reads return 32'hDEAD_BEEF
// with SLVERR. Writes to RO offsets are ignored with OKAY.
//
// Ports:
//   user_clk, user_reset      clock, synchronous active-high reset
//   s_axil_aw* / s_axil_w*    write address / data channels
//   s_axil_b*                 write response channel
//   s_axil_ar* / s_axil_r*    read address / data channels
//   led[2:0]                  led[2:1] = CTRL[2:1],
//                             led[0]   = CTRL[3] ? CYCLES[HB_BIT] : CTRL[0]
//
// Build option: define PCIE_AXIL_REGS_WSTRB_EN to make SCRATCH and CTRL
// writes honour wstrb per byte lane; otherwise every write updates the
// full word.
module pcie_axil_regs #(
    parameter logic [31:0] ID_VALUE = 32'h7C1E_0001,
    parameter int          HB_BIT   = 26
) (
    input  logic        user_clk,
    input  logic        user_reset,
    input  logic [11:0] s_axil_awaddr,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    input  logic [11:0] s_axil_araddr,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic [2:0]  led
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} hold_t;

    hold_t       aw_state, aw_state_nxt;
    hold_t       w_state, w_state_nxt;
    logic [9:0]  aw_idx;
    logic [31:0] w_data;
    logic [31:0] wmask;
    logic [31:0] scratch;
    logic [3:0]  ctrl;
    logic [31:0] cycles;
    logic [31:0] wrcnt;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        aw_hs, w_hs, ar_hs, do_write;

    assign s_axil_awready = (aw_state == EMPTY) && !s_axil_bvalid;
    assign s_axil_wready  = (w_state == EMPTY) && !s_axil_bvalid;
    assign s_axil_arready = !s_axil_rvalid;

    assign aw_hs    = s_axil_awvalid && s_axil_awready;
    assign w_hs     = s_axil_wvalid && s_axil_wready;
    assign ar_hs    = s_axil_arvalid && s_axil_arready;
    // The register update waits one edge after the second half arrives so
    // that address and data always come from the holding registers.
    assign do_write = (aw_state == HELD) && (w_state == HELD);

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            aw_state <= EMPTY;
            w_state  <= EMPTY;
        end else begin
            aw_state <= aw_state_nxt;
            w_state  <= w_state_nxt;
        end
    end

    always_comb begin
        aw_state_nxt = aw_state;
        w_state_nxt  = w_state;
        if (do_write) begin
            aw_state_nxt = EMPTY;
            w_state_nxt  = EMPTY;
        end else begin
            if (aw_hs) aw_state_nxt = HELD;
            if (w_hs)  w_state_nxt  = HELD;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            aw_idx <= '0;
            w_data <= '0;
        end else begin
            if (aw_hs) aw_idx <= s_axil_awaddr[11:2];
            if (w_hs)  w_data <= s_axil_wdata;
        end
    end

`ifdef PCIE_AXIL_REGS_WSTRB_EN
    logic [3:0] w_strb;
    logic       unused_addr_lsbs;

    always_ff @(posedge user_clk) begin
        if (user_reset)
            w_strb <= '0;
        else if (w_hs)
            w_strb <= s_axil_wstrb;
    end

    assign wmask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
`else
    logic unused_addr_lsbs;

    assign wmask = 32'hFFFF_FFFF;
    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], s_axil_wstrb};
`endif

    // Register update and write response. Only offsets 0..4 are mapped;
    // anything above gets SLVERR even though nothing is written.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            scratch       <= '0;
            ctrl          <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            if (do_write) begin
                case (aw_idx)
                    10'd1:   scratch <= (scratch & ~wmask) | (w_data & wmask);
                    10'd2:   ctrl    <= (ctrl & ~wmask[3:0]) | (w_data[3:0] & wmask[3:0]);
                    default: ;
                endcase
                s_axil_bresp  <= (aw_idx <= 10'd4) ? RESP_OKAY : RESP_SLVERR;
                s_axil_bvalid <= 1'b1;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    // WRCNT counts B handshakes, so a reset that drops a pending response
    // never counts it.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            cycles <= '0;
            wrcnt  <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (s_axil_bvalid && s_axil_bready)
                wrcnt <= wrcnt + 32'd1;
        end
    end

    always_comb begin
        rd_data = 32'hDEAD_BEEF;
        rd_resp = RESP_SLVERR;
        case (s_axil_araddr[11:2])
            10'd0: begin rd_data = ID_VALUE;          rd_resp = RESP_OKAY; end
            10'd1: begin rd_data = scratch;           rd_resp = RESP_OKAY; end
            10'd2: begin rd_data = {28'd0, ctrl};     rd_resp = RESP_OKAY; end
            10'd3: begin rd_data = cycles;            rd_resp = RESP_OKAY; end
            10'd4: begin rd_data = wrcnt;             rd_resp = RESP_OKAY; end
            default: ;
        endcase
    end

    // Read data is captured at the AR handshake and held until rready, so a
    // same-cycle write is not visible to the read.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_data;
            s_axil_rresp  <= rd_resp;
        end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

    assign led = {ctrl[2], ctrl[1], ctrl[3] ? cycles[HB_BIT] : ctrl[0]};

endmodule
